// File: rtl/bram_arb_pkg.sv
// Shared definitions for the two-port BRAM arbiter.
//   state_t   : arbiter FSM states (INIT clear sweep, SERVE requester traffic)
//   NUM_PORTS : number of requester ports
package bram_arb_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    SERVE = 1'b1
  } state_t;

  localparam int NUM_PORTS = 2;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin grant decision.
// Ports:
//   valids  in  [1:0]  request pending per port
//   pointer in         preferred port on contention (0 or 1)
//   grant   out [1:0]  one-hot grant (all zero when nothing is valid)
module rr_arbiter_2
  import bram_arb_pkg::*;
(
  input  logic [NUM_PORTS-1:0] valids,
  input  logic                 pointer,
  output logic [NUM_PORTS-1:0] grant
);

  always_comb begin
    grant = '0;
    if (valids[0] && valids[1]) begin
      grant[pointer] = 1'b1;
    end else begin
      // A lone requester wins regardless of the pointer, no idle cycle.
      grant = valids;
    end
  end

endmodule

// File: rtl/bram_arbiter.sv
// Two-port arbiter in front of a single-port BRAM with registered read data.
// Optional feature macro: BRAM_ARB_INIT_CLEAR_EN -- when defined, the memory is
// cleared to zero (one address per cycle) after reset before traffic is served.
// Ports:
//   clock, reset_n                      clock, asynchronous active-low reset
//   req_valid_p/req_ready_p             request handshake, p = 0/1
//   req_write_p/req_address_p/req_data_p request attributes
//   rsp_valid_p/rsp_data_p              response, one cycle after the grant
//   ram_enable/write_enable/address/input_data  RAM controls and write data
//   output_data                         RAM registered read data
//   init_done                           memory ready for requester traffic
module bram_arbiter
  import bram_arb_pkg::*;
#(
  parameter int RAM_WIDTH     = 32,
  parameter int RAM_ADDR_BITS = 9
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     req_valid_0,
  output logic                     req_ready_0,
  input  logic                     req_write_0,
  input  logic [RAM_ADDR_BITS-1:0] req_address_0,
  input  logic [RAM_WIDTH-1:0]     req_data_0,
  output logic                     rsp_valid_0,
  output logic [RAM_WIDTH-1:0]     rsp_data_0,
  input  logic                     req_valid_1,
  output logic                     req_ready_1,
  input  logic                     req_write_1,
  input  logic [RAM_ADDR_BITS-1:0] req_address_1,
  input  logic [RAM_WIDTH-1:0]     req_data_1,
  output logic                     rsp_valid_1,
  output logic [RAM_WIDTH-1:0]     rsp_data_1,
  output logic                     ram_enable,
  output logic                     write_enable,
  output logic [RAM_ADDR_BITS-1:0] address,
  output logic [RAM_WIDTH-1:0]     input_data,
  input  logic [RAM_WIDTH-1:0]     output_data,
  output logic                     init_done
);

  logic                     serving;
  logic [RAM_ADDR_BITS-1:0] sweep_address;
  logic [NUM_PORTS-1:0]     valids;
  logic [NUM_PORTS-1:0]     grant;
  logic                     pointer;
  logic [NUM_PORTS-1:0]     rsp_vld_p1;

`ifdef BRAM_ARB_INIT_CLEAR_EN
  localparam logic [RAM_ADDR_BITS-1:0] LAST_ADDR = '1;

  state_t                   state;
  state_t                   state_next;
  logic [RAM_ADDR_BITS-1:0] sweep_count;
  logic [RAM_ADDR_BITS-1:0] sweep_count_next;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= INIT;
      sweep_count <= '0;
    end else begin
      state       <= state_next;
      sweep_count <= sweep_count_next;
    end
  end

  // The counter stops on the last address instead of wrapping, so leaving
  // INIT is the only way out of the sweep.
  always_comb begin
    state_next       = state;
    sweep_count_next = sweep_count;
    if (state == INIT) begin
      if (sweep_count == LAST_ADDR) begin
        state_next = SERVE;
      end else begin
        sweep_count_next = sweep_count + 1'b1;
      end
    end
  end

  assign serving       = (state == SERVE);
  assign sweep_address = sweep_count;
  assign init_done     = serving;
`else
  logic done_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b1;
    end
  end

  assign serving       = 1'b1;
  assign sweep_address = '0;
  assign init_done     = done_q;
`endif

  // Stage p0: arbitration and combinational RAM command mux
  assign valids = {req_valid_1, req_valid_0} & {NUM_PORTS{serving}};

  rr_arbiter_2 u_rr_arbiter_2 (
    .valids  (valids),
    .pointer (pointer),
    .grant   (grant)
  );

  assign req_ready_0 = grant[0];
  assign req_ready_1 = grant[1];

  always_comb begin
    ram_enable   = 1'b0;
    write_enable = 1'b0;
    address      = '0;
    input_data   = '0;
    if (!serving) begin
      ram_enable   = 1'b1;
      write_enable = 1'b1;
      address      = sweep_address;
    end else if (grant[0]) begin
      ram_enable   = 1'b1;
      write_enable = req_write_0;
      address      = req_address_0;
      input_data   = req_data_0;
    end else if (grant[1]) begin
      ram_enable   = 1'b1;
      write_enable = req_write_1;
      address      = req_address_1;
      input_data   = req_data_1;
    end
  end

  // Stage p1: response valid tracks the grant; data comes straight from the RAM
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pointer    <= 1'b0;
      rsp_vld_p1 <= '0;
    end else begin
      rsp_vld_p1 <= grant;
      // After a grant, prefer the port that was not just served.
      if (|grant) begin
        pointer <= grant[0];
      end
    end
  end

  assign rsp_valid_0 = rsp_vld_p1[0];
  assign rsp_valid_1 = rsp_vld_p1[1];
  assign rsp_data_0  = output_data;
  assign rsp_data_1  = output_data;

endmodule

// File: tb/tb_bram_arbiter.sv
// Testbench for bram_arbiter: table-driven directed rows, randomized traffic
// against a behavioural memory/round-robin model, and reset corner cases.
// Works with or without BRAM_ARB_INIT_CLEAR_EN defined.
module tb_bram_arbiter;

  localparam int W     = 32;
  localparam int AB    = 4;
  localparam int DEPTH = 16;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          req_valid_0, req_ready_0, req_write_0;
  logic [AB-1:0] req_address_0;
  logic [W-1:0]  req_data_0, rsp_data_0;
  logic          rsp_valid_0;
  logic          req_valid_1, req_ready_1, req_write_1;
  logic [AB-1:0] req_address_1;
  logic [W-1:0]  req_data_1, rsp_data_1;
  logic          rsp_valid_1;
  logic          ram_enable, write_enable, init_done;
  logic [AB-1:0] address;
  logic [W-1:0]  input_data, output_data;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  bram_arbiter #(.RAM_WIDTH(W), .RAM_ADDR_BITS(AB)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid_0(req_valid_0), .req_ready_0(req_ready_0), .req_write_0(req_write_0),
    .req_address_0(req_address_0), .req_data_0(req_data_0),
    .rsp_valid_0(rsp_valid_0), .rsp_data_0(rsp_data_0),
    .req_valid_1(req_valid_1), .req_ready_1(req_ready_1), .req_write_1(req_write_1),
    .req_address_1(req_address_1), .req_data_1(req_data_1),
    .rsp_valid_1(rsp_valid_1), .rsp_data_1(rsp_data_1),
    .ram_enable(ram_enable), .write_enable(write_enable), .address(address),
    .input_data(input_data), .output_data(output_data), .init_done(init_done)
  );

  // Single-port RAM with registered, read-first output.
  logic [W-1:0] ram [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) ram[i] = $urandom;
  always @(posedge clock) begin
    if (ram_enable) begin
      output_data <= ram[address];
      if (write_enable) ram[address] <= input_data;
    end
  end

  // Behavioural reference state.
  logic [W-1:0] mdl_mem [DEPTH];
  bit           mdl_known [DEPTH];
  bit           mdl_pref;          // port that wins the next contention
  bit           exp_rv0, exp_rv1;
  logic [W-1:0] exp_rd;
  bit           exp_rd_known;

  typedef struct {
    bit v0; bit w0; logic [AB-1:0] a0; logic [W-1:0] d0;
    bit v1; bit w1; logic [AB-1:0] a1; logic [W-1:0] d1;
    bit r0; bit r1; bit rv0; bit rv1; bit chk; logic [W-1:0] ed;
  } vec_t;
  vec_t tbl [12];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit v0, input bit w0, input logic [AB-1:0] a0, input logic [W-1:0] d0,
                       input bit v1, input bit w1, input logic [AB-1:0] a1, input logic [W-1:0] d1);
    req_valid_0 = v0; req_write_0 = w0; req_address_0 = a0; req_data_0 = d0;
    req_valid_1 = v1; req_write_1 = w1; req_address_1 = a1; req_data_1 = d1;
  endtask

  task automatic model_reset();
    mdl_pref = 1'b0;
    exp_rv0 = 1'b0;
    exp_rv1 = 1'b0;
    exp_rd_known = 1'b0;
  endtask

  // Called between edges with the inputs for this cycle already applied.
  task automatic model_cycle(input bit compare);
    bit g0, g1, w;
    logic [AB-1:0] a;
    logic [W-1:0] d;
    g0 = req_valid_0 && (!req_valid_1 || !mdl_pref);
    g1 = req_valid_1 && !g0;
    w  = g0 ? req_write_0 : req_write_1;
    a  = g0 ? req_address_0 : req_address_1;
    d  = g0 ? req_data_0 : req_data_1;
    if (compare) begin
      check("rnd_ready_0", req_ready_0, g0);
      check("rnd_ready_1", req_ready_1, g1);
      check("rnd_ram_enable", ram_enable, g0 | g1);
      check("rnd_write_enable", write_enable, (g0 | g1) & w);
      if (g0 | g1) check("rnd_address", address, a);
      if ((g0 | g1) && w) check("rnd_input_data", input_data, d);
      check("rnd_rsp_valid_0", rsp_valid_0, exp_rv0);
      check("rnd_rsp_valid_1", rsp_valid_1, exp_rv1);
      if (exp_rv0 && exp_rd_known) check("rnd_rsp_data_0", rsp_data_0, exp_rd);
      if (exp_rv1 && exp_rd_known) check("rnd_rsp_data_1", rsp_data_1, exp_rd);
    end
    exp_rv0 = g0;
    exp_rv1 = g1;
    if (g0 | g1) begin
      exp_rd       = mdl_mem[a];
      exp_rd_known = mdl_known[a];
      if (w) begin
        mdl_mem[a]   = d;
        mdl_known[a] = 1'b1;
      end
      mdl_pref = g0;
    end
  endtask

`ifdef BRAM_ARB_INIT_CLEAR_EN
  // Entered at a negedge just after reset release; leaves at a negedge.
  task automatic sweep_check();
    drive(1, 1, 4'h2, 32'h55, 1, 0, 4'h3, 32'h0);
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      check("sweep_enable", ram_enable, 1'b1);
      check("sweep_write_enable", write_enable, 1'b1);
      check("sweep_address", address, i[AB-1:0]);
      check("sweep_data", input_data, '0);
      check("sweep_ready_0", req_ready_0, 1'b0);
      check("sweep_ready_1", req_ready_1, 1'b0);
      check("sweep_init_done", init_done, 1'b0);
      @(negedge clock);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("init_done_after_sweep", init_done, 1'b1);
    check("no_second_sweep", ram_enable, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      mdl_mem[i]   = '0;
      mdl_known[i] = 1'b1;
    end
    @(negedge clock);
  endtask
`endif

  initial begin
    tbl[0]  = '{1,1,4'h5,32'hDEADBEEF, 0,0,4'h0,32'h0, 1,0,0,0,0,32'h0};
    tbl[1]  = '{1,0,4'h5,32'h0,        0,0,4'h0,32'h0, 1,0,1,0,0,32'h0};
    tbl[2]  = '{0,0,4'h0,32'h0,        1,1,4'h3,32'h7, 0,1,1,0,1,32'hDEADBEEF};
    tbl[3]  = '{0,0,4'h0,32'h0,        0,0,4'h0,32'h0, 0,0,0,1,0,32'h0};
    tbl[4]  = '{1,1,4'h3,32'h1,        0,0,4'h0,32'h0, 1,0,0,0,0,32'h0};
    tbl[5]  = '{0,0,4'h0,32'h0,        0,0,4'h0,32'h0, 0,0,1,0,1,32'h7};
    tbl[6]  = '{1,0,4'h3,32'h0,        1,0,4'h5,32'h0, 0,1,0,0,0,32'h0};
    tbl[7]  = '{1,0,4'h3,32'h0,        1,0,4'h5,32'h0, 1,0,0,1,1,32'hDEADBEEF};
    tbl[8]  = '{1,0,4'h3,32'h0,        1,0,4'h5,32'h0, 0,1,1,0,1,32'h1};
    tbl[9]  = '{1,0,4'h3,32'h0,        1,0,4'h5,32'h0, 1,0,0,1,1,32'hDEADBEEF};
    tbl[10] = '{0,0,4'h0,32'h0,        0,0,4'h0,32'h0, 0,0,1,0,1,32'h1};
    tbl[11] = '{0,0,4'h0,32'h0,        0,0,4'h0,32'h0, 0,0,0,0,0,32'h0};

    for (int i = 0; i < DEPTH; i++) mdl_known[i] = 1'b0;
    model_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    check("reset_rsp_valid_0", rsp_valid_0, 1'b0);
    check("reset_rsp_valid_1", rsp_valid_1, 1'b0);
    check("reset_init_done", init_done, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
`ifdef BRAM_ARB_INIT_CLEAR_EN
    sweep_check();
`else
    #1;
    check("init_done_before_edge", init_done, 1'b0);
    @(negedge clock);
    #1;
    check("init_done_after_reset", init_done, 1'b1);
    @(negedge clock);
`endif

    // Directed rows: single-port, read-first, contention.
    for (int r = 0; r < 12; r++) begin
      drive(tbl[r].v0, tbl[r].w0, tbl[r].a0, tbl[r].d0, tbl[r].v1, tbl[r].w1, tbl[r].a1, tbl[r].d1);
      #1;
      check($sformatf("row%0d_ready_0", r), req_ready_0, tbl[r].r0);
      check($sformatf("row%0d_ready_1", r), req_ready_1, tbl[r].r1);
      check($sformatf("row%0d_ram_enable", r), ram_enable, tbl[r].r0 | tbl[r].r1);
      check($sformatf("row%0d_rsp_valid_0", r), rsp_valid_0, tbl[r].rv0);
      check($sformatf("row%0d_rsp_valid_1", r), rsp_valid_1, tbl[r].rv1);
      if (tbl[r].chk)
        check($sformatf("row%0d_rsp_data", r), tbl[r].rv0 ? rsp_data_0 : rsp_data_1, tbl[r].ed);
      model_cycle(1'b0);
      @(negedge clock);
    end

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 1), AB'($urandom_range(0, DEPTH - 1)), $urandom,
            $urandom_range(0, 9) < 7, $urandom_range(0, 1), AB'($urandom_range(0, DEPTH - 1)), $urandom);
      #1;
      model_cycle(1'b1);
      @(negedge clock);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    model_cycle(1'b1);
    @(negedge clock);

    // Reset during a pending response drops it immediately.
    drive(1, 0, 4'h1, 0, 0, 0, 0, 0);
    @(posedge clock);
    #2;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("pending_rsp_before_reset", rsp_valid_0, 1'b1);
    reset_n = 1'b0;
    #1;
    check("rsp_dropped_by_reset", rsp_valid_0, 1'b0);
    check("init_done_in_reset", init_done, 1'b0);
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
`ifdef BRAM_ARB_INIT_CLEAR_EN
    // Interrupt the sweep at address 9; it must restart from 0.
    repeat (9) @(negedge clock);
    #1;
    check("sweep_at_addr9", address, 4'h9);
    reset_n = 1'b0;
    #1;
    check("sweep_addr_in_reset", address, 4'h0);
    check("init_done_mid_sweep_reset", init_done, 1'b0);
    check("rsp_valid_mid_sweep_reset", rsp_valid_0 | rsp_valid_1, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    sweep_check();
`else
    #1;
    check("init_done_before_edge2", init_done, 1'b0);
    @(negedge clock);
    #1;
    check("init_done_after_reset2", init_done, 1'b1);
    @(negedge clock);
`endif

    // Short traffic burst after the second reset.
    for (int c = 0; c < 60; c++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 1), AB'($urandom_range(0, DEPTH - 1)), $urandom,
            $urandom_range(0, 1), $urandom_range(0, 1), AB'($urandom_range(0, DEPTH - 1)), $urandom);
      #1;
      model_cycle(1'b1);
      @(negedge clock);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bram_arbiter.md
BRAM_ARBITER -- requirements
Module: bram_arbiter

Interface
REQ-001 Parameter RAM_WIDTH, default 32, SHALL set the data width in bits.
REQ-002 Parameter RAM_ADDR_BITS, default 9, SHALL set the address width; depth = 2**RAM_ADDR_BITS.
REQ-003 clock  in  1  single clock; all state on posedge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 req_valid_0/1  in  1  requester p has an access pending.
REQ-006 req_ready_0/1  out  1  requester p's access is accepted this cycle.
REQ-007 req_write_0/1  in  1  1 = write, 0 = read.
REQ-008 req_address_0/1  in  RAM_ADDR_BITS  access address.
REQ-009 req_data_0/1  in  RAM_WIDTH  write data.
REQ-010 rsp_valid_0/1  out  1  response for requester p.
REQ-011 rsp_data_0/1  out  RAM_WIDTH  read data.
REQ-012 ram_enable, write_enable  out  1  single-port RAM controls.
REQ-013 address  out  RAM_ADDR_BITS  RAM address.
REQ-014 input_data  out  RAM_WIDTH  RAM write data.
REQ-015 output_data  in  RAM_WIDTH  RAM registered read data, valid one cycle after enable.
REQ-016 init_done  out  1  memory is ready for requester traffic.

Function
REQ-017 The FSM SHALL have two states: INIT and SERVE.
REQ-018 In SERVE, at most one requester SHALL be granted per cycle; a grant is req_valid_p && req_ready_p.
REQ-019 Arbitration SHALL be round-robin: on contention the port not granted most recently wins; with a single valid request, that port wins with no idle cycle.
REQ-020 req_ready_p SHALL be combinational from req_valid and the priority pointer, and SHALL be 0 in INIT.
REQ-021 On grant, ram_enable=1 and write_enable/address/input_data SHALL be muxed combinationally from the granted port in the same cycle; with no grant, ram_enable=0 and write_enable=0.
REQ-022 rsp_valid_p SHALL assert exactly one cycle after a grant to port p, for one cycle, for both reads and writes.
REQ-023 rsp_data_p SHALL equal output_data whenever rsp_valid_p=1, giving read-first data (old contents on a write); otherwise rsp_data_p is don't-care.
REQ-024 Responses SHALL have no backpressure; back-to-back grants SHALL give back-to-back responses at full throughput.
REQ-025 The priority pointer SHALL update only on a grant, and SHALL point to the other port.
REQ-026 The INIT sweep SHALL write zero to addresses 0 to 2**RAM_ADDR_BITS-1, one per cycle, using an RAM_ADDR_BITS-wide counter.
REQ-027 After the last address is written, the FSM SHALL enter SERVE and set init_done=1, which then stays 1 until reset.
REQ-028 The sweep SHALL take exactly 2**RAM_ADDR_BITS cycles, and the sweep counter SHALL NOT wrap back into a second sweep.

Reset
REQ-029 While reset_n=0: rsp_valid_0/1=0, init_done=0, pointer prefers port 0, sweep counter=0, and the state is INIT (with BRAM_ARB_INIT_CLEAR_EN) or SERVE.
REQ-030 Reset asserted mid-sweep or mid-access SHALL take effect immediately; a pending rsp_valid SHALL be dropped, and the sweep SHALL restart from address 0.

Configuration
REQ-031 The macro BRAM_ARB_INIT_CLEAR_EN SHALL control the INIT clear sweep.
REQ-032 With BRAM_ARB_INIT_CLEAR_EN defined, REQ-026..028 SHALL apply.
REQ-033 Without BRAM_ARB_INIT_CLEAR_EN, INIT and the sweep counter SHALL be absent, and SERVE SHALL be entered directly from reset.
REQ-034 Without BRAM_ARB_INIT_CLEAR_EN, init_done SHALL be 1 in the first cycle after reset_n rises.

Structure
REQ-035 Package bram_arb_pkg SHALL hold the state enum (INIT, SERVE) and the constant NUM_PORTS=2.
REQ-036 The round-robin decision SHALL live in sub-module rr_arbiter_2 (inputs: valids, pointer; outputs: one-hot grant).

Verification
REQ-037 Clear-sweep test, RAM_ADDR_BITS=4, macro on: after reset -> 16 zero writes to addresses 0..15, then init_done=1 at cycle 16, req_ready=0 throughout.
REQ-038 Single-port test: port 0 writes 0xDEADBEEF to 0x05, then reads 0x05 -> read rsp_data_0=0xDEADBEEF, one cycle after its grant.
REQ-039 Contention test: both ports valid continuously -> grants alternate 0,1,0,1 and each rsp_valid pulses every other cycle.
REQ-040 Read-first test: write 0x1 over stored 0x7 at 0x03 -> rsp_data=0x7 on the write response.
REQ-041 Reset test: reset_n pulsed low mid-sweep at address 9 -> rsp_valid cleared, sweep restarts at 0; macro off -> init_done=1 one cycle after reset release.
